// File: rtl/adc_pipe_stage_emulator_if.sv
// Sample-source / stage-code bundle of the ADC pipe stage emulator.
// ADC_EMU_OFFSET_EN adds the stage-1 comparator offset input.
interface adc_pipe_stage_emulator_if #(
  parameter int IN_BITS = 6
);
  logic                     mode_i;
  logic                     start_i;
  logic [IN_BITS-1:0]       sample_i;
  logic                     sample_valid_i;
`ifdef ADC_EMU_OFFSET_EN
  logic signed [IN_BITS-3:0] offset_i;
`endif
  logic [2:0]               d1_o;
  logic [2:0]               d2_o;
  logic                     d3_o;
  logic                     valid_o;
  logic                     busy_o;
  logic                     done_o;

  modport master (
    output mode_i, start_i, sample_i, sample_valid_i,
`ifdef ADC_EMU_OFFSET_EN
    output offset_i,
`endif
    input  d1_o, d2_o, d3_o, valid_o, busy_o, done_o
  );

  modport slave (
    input  mode_i, start_i, sample_i, sample_valid_i,
`ifdef ADC_EMU_OFFSET_EN
    input  offset_i,
`endif
    output d1_o, d2_o, d3_o, valid_o, busy_o, done_o
  );
endinterface

// File: rtl/adc_pipe_stage_emulator.sv
// Behavioural 3-stage pipelined ADC front-end (1.5b, 1.5b, 1b) used as a BIST source.
// Optional ADC_EMU_OFFSET_EN: stage-1 decision sees x + offset_i, residue uses true x.
module adc_pipe_stage_emulator #(
  parameter int IN_BITS   = 6,
  parameter int RAMP_STEP = 1
) (
  input logic                   clock_i,
  input logic                   reset_i,
  adc_pipe_stage_emulator_if.slave bus
);

  localparam int W  = IN_BITS + 2;
  localparam int CW = IN_BITS + 2;
  localparam logic signed [W-1:0] L_VREF = W'(1 << (IN_BITS - 1));
  localparam logic signed [W-1:0] L_QTR  = W'(1 << (IN_BITS - 3));
  localparam logic [CW-1:0]       L_STEP = CW'(RAMP_STEP);
  localparam logic [CW-1:0]       L_MAX  = CW'((1 << IN_BITS) - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  function automatic logic [1:0] decide(input logic signed [W-1:0] x);
    logic [1:0] d;
    if (x < -L_QTR) begin
      d = 2'd0;
    end else if (x < L_QTR) begin
      d = 2'd1;
    end else begin
      d = 2'd2;
    end
    return d;
  endfunction

  function automatic logic signed [W-1:0] residue(input logic signed [W-1:0] x,
                                                   input logic [1:0] d);
    logic signed [W-1:0] r;
    case (d)
      2'd0:    r = (x <<< 1) + L_VREF;
      2'd1:    r = (x <<< 1);
      2'd2:    r = (x <<< 1) - L_VREF;
      default: r = (x <<< 1);
    endcase
    return r;
  endfunction

  function automatic logic [2:0] pin(input logic [1:0] d);
    logic [2:0] p;
    case (d)
      2'd0:    p = 3'b010;
      2'd1:    p = 3'b001;
      2'd2:    p = 3'b100;
      default: p = 3'b000;
    endcase
    return p;
  endfunction

  state_t              r_state;
  logic [IN_BITS-1:0]  r_cnt;
  logic [1:0]          r_drain;
  logic                r_busy;
  logic                r_done;

  logic                r_v1, r_v2, r_v3;
  logic [2:0]          r_d1, r_d2;
  logic                r_d3;
  logic signed [W-1:0] r_res1, r_res2;

  logic                w_in_valid;
  logic [IN_BITS-1:0]  w_in_sample;
  logic signed [W-1:0] w_x;
  logic [1:0]          w_dec1;
  logic [1:0]          w_dec2;
  logic [CW-1:0]       w_cnt_next;
  logic                w_last;

  // Source select: ramp counter while running, external stream only when idle in mode 0.
  always_comb begin
    w_in_valid  = 1'b0;
    w_in_sample = {IN_BITS{1'b0}};
    case (r_state)
      ST_RUN: begin
        w_in_valid  = 1'b1;
        w_in_sample = r_cnt;
      end
      ST_IDLE: begin
        w_in_valid  = bus.sample_valid_i & ~bus.mode_i;
        w_in_sample = bus.sample_i;
      end
      default: begin
        w_in_valid  = 1'b0;
        w_in_sample = {IN_BITS{1'b0}};
      end
    endcase
  end

  assign w_x        = $signed({2'b00, w_in_sample}) - L_VREF;
`ifdef ADC_EMU_OFFSET_EN
  assign w_dec1     = decide(w_x + {{(W-(IN_BITS-2)){bus.offset_i[IN_BITS-3]}}, bus.offset_i});
`else
  assign w_dec1     = decide(w_x);
`endif
  assign w_dec2     = decide(r_res1);
  assign w_cnt_next = {2'b00, r_cnt} + L_STEP;
  assign w_last     = (w_cnt_next > L_MAX);

  // Ramp sequencer; done fires as the last ramp sample leaves stage 3.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      r_state <= ST_IDLE;
      r_cnt   <= {IN_BITS{1'b0}};
      r_drain <= 2'd0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.start_i && bus.mode_i) begin
            r_state <= ST_RUN;
            r_cnt   <= {IN_BITS{1'b0}};
            r_busy  <= 1'b1;
          end
        end
        ST_RUN: begin
          if (w_last) begin
            r_state <= ST_DRAIN;
            r_drain <= 2'd0;
          end else begin
            r_cnt <= w_cnt_next[IN_BITS-1:0];
          end
        end
        ST_DRAIN: begin
          r_drain <= r_drain + 2'd1;
          if (r_drain == 2'd1) begin
            r_done <= 1'b1;
          end
          if (r_drain == 2'd2) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Three-stage pipeline; stage data holds when no sample advances.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      r_v1   <= 1'b0;
      r_v2   <= 1'b0;
      r_v3   <= 1'b0;
      r_d1   <= 3'b000;
      r_d2   <= 3'b000;
      r_d3   <= 1'b0;
      r_res1 <= {W{1'b0}};
      r_res2 <= {W{1'b0}};
    end else begin
      r_v1 <= w_in_valid;
      r_v2 <= r_v1;
      r_v3 <= r_v2;
      if (w_in_valid) begin
        r_d1   <= pin(w_dec1);
        r_res1 <= residue(w_x, w_dec1);
      end
      if (r_v1) begin
        r_d2   <= pin(w_dec2);
        r_res2 <= residue(r_res1, w_dec2);
      end
      if (r_v2) begin
        r_d3 <= ~r_res2[W-1];
      end
    end
  end

  assign bus.d1_o    = r_d1;
  assign bus.d2_o    = r_d2;
  assign bus.d3_o    = r_d3;
  assign bus.valid_o = r_v3;
  assign bus.busy_o  = r_busy;
  assign bus.done_o  = r_done;

endmodule

// File: tb/tb_adc_pipe_stage_emulator.sv
// Directed bench for adc_pipe_stage_emulator: two instances (RAMP_STEP 1 and 5).
// Build with ADC_EMU_OFFSET_EN to also exercise the comparator-offset input.
module tb_adc_pipe_stage_emulator;

  logic       clk = 1'b0;
  logic       rst;
  logic       mode, start, sv;
  logic [5:0] sample;
  int         sel;
  int         n_assert = 0;
  int         n_fail   = 0;
`ifdef ADC_EMU_OFFSET_EN
  logic signed [3:0] offset = 4'sd0;
`endif

  adc_pipe_stage_emulator_if #(.IN_BITS(6)) if0 ();
  adc_pipe_stage_emulator_if #(.IN_BITS(6)) if1 ();

  assign if0.mode_i         = mode;
  assign if1.mode_i         = mode;
  assign if0.start_i        = start & (sel == 0);
  assign if1.start_i        = start & (sel == 1);
  assign if0.sample_i       = sample;
  assign if1.sample_i       = sample;
  assign if0.sample_valid_i = sv;
  assign if1.sample_valid_i = sv;
`ifdef ADC_EMU_OFFSET_EN
  assign if0.offset_i = offset;
  assign if1.offset_i = offset;
`endif

  adc_pipe_stage_emulator #(.IN_BITS(6), .RAMP_STEP(1)) u0 (.clock_i(clk), .reset_i(rst), .bus(if0));
  adc_pipe_stage_emulator #(.IN_BITS(6), .RAMP_STEP(5)) u1 (.clock_i(clk), .reset_i(rst), .bus(if1));

  logic [2:0] o_d1, o_d2;
  logic       o_d3, o_valid, o_busy, o_done;
  assign o_d1    = (sel == 1) ? if1.d1_o    : if0.d1_o;
  assign o_d2    = (sel == 1) ? if1.d2_o    : if0.d2_o;
  assign o_d3    = (sel == 1) ? if1.d3_o    : if0.d3_o;
  assign o_valid = (sel == 1) ? if1.valid_o : if0.valid_o;
  assign o_busy  = (sel == 1) ? if1.busy_o  : if0.busy_o;
  assign o_done  = (sel == 1) ? if1.done_o  : if0.done_o;

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Start a ramp on the selected instance and follow it to done.
  task automatic run_ramp(input int exp_n, input bit poke_start);
    int  nv, first, k_done;
    bit  got;
    nv = 0; first = -1; k_done = 0; got = 1'b0;
    mode = 1'b1; start = 1'b1; sv = 1'b0;
    tick;
    chk("busy_rises", o_busy, 1);
    start = 1'b0;
    for (int k = 0; k < 200; k++) begin
      sv     = k[0];
      sample = 6'd5;
      start  = (poke_start && k == 4) ? 1'b1 : 1'b0;
      tick;
      if (o_valid) begin
        nv++;
        if (first < 0) first = k;
      end
      if (o_done) begin
        got    = 1'b1;
        k_done = k;
        break;
      end
    end
    chk("done_seen", got, 1);
    chk("valid_count_at_done", nv, exp_n);
    chk("valid_at_done", o_valid, 1);
    chk("valid_contiguous", k_done - first + 1, exp_n);
    sv = 1'b0; start = 1'b0;
    tick;
    chk("busy_falls", o_busy, 0);
    chk("no_valid_after", o_valid, 0);
    chk("done_one_cycle", o_done, 0);
    mode = 1'b0;
  endtask

  initial begin
    int extra;
    rst = 1'b1; mode = 1'b0; start = 1'b0; sv = 1'b0; sample = 6'd0; sel = 0;
    tick; tick;
    chk("rst_d1", o_d1, 3'b000);
    chk("rst_d2", o_d2, 3'b000);
    chk("rst_d3", o_d3, 0);
    chk("rst_valid", o_valid, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_done", o_done, 0);
    rst = 1'b0;
    tick;

    // External samples 0, 63, 32 back to back.
    sample = 6'd0; sv = 1'b1; tick;
    chk("ext0_d1", o_d1, 3'b010);
    chk("ext0_valid_early", o_valid, 0);
    sample = 6'd63; tick;
    chk("ext63_d1", o_d1, 3'b100);
    chk("ext0_d2", o_d2, 3'b010);
    sample = 6'd32; tick;
    chk("ext32_d1", o_d1, 3'b001);
    chk("ext63_d2", o_d2, 3'b100);
    chk("ext0_d3", o_d3, 0);
    chk("ext0_valid", o_valid, 1);
    sv = 1'b0; tick;
    chk("ext32_d2", o_d2, 3'b001);
    chk("ext63_d3", o_d3, 1);
    chk("ext63_valid", o_valid, 1);
    tick;
    chk("ext32_d3", o_d3, 1);
    chk("ext32_valid", o_valid, 1);
    tick;
    chk("ext_idle_valid", o_valid, 0);
    chk("ext_hold_d1", o_d1, 3'b001);

    // Threshold samples 40, 39, 24.
    sample = 6'd40; sv = 1'b1; tick;
    chk("thr40_d1", o_d1, 3'b100);
    sample = 6'd39; tick;
    chk("thr39_d1", o_d1, 3'b001);
    chk("thr40_d2", o_d2, 3'b010);
    sample = 6'd24; tick;
    chk("thr24_d1", o_d1, 3'b001);
    chk("thr39_d2", o_d2, 3'b100);
    chk("thr40_d3", o_d3, 1);
    sv = 1'b0; tick;
    chk("thr24_d2", o_d2, 3'b010);
    chk("thr39_d3", o_d3, 0);
    tick;
    chk("thr24_d3", o_d3, 1);
    tick;

    // Mode 1 while idle: external samples are not accepted.
    mode = 1'b1; sv = 1'b1; sample = 6'd63;
    extra = 0;
    for (int i = 0; i < 5; i++) begin
      tick;
      if (o_valid) extra++;
    end
    chk("mode1_idle_no_valid", extra, 0);
    sv = 1'b0; mode = 1'b0;

    sel = 0;
    run_ramp(64, 1'b0);

    sel = 1;
    run_ramp(13, 1'b1);
    extra = 0;
    for (int i = 0; i < 6; i++) begin
      tick;
      if (o_busy || o_valid || o_done) extra++;
    end
    chk("step5_stays_idle", extra, 0);

    // Reset on the 10th RUN cycle aborts the ramp.
    sel = 0;
    mode = 1'b1; start = 1'b1; tick;
    start = 1'b0;
    for (int i = 0; i < 9; i++) tick;
    chk("abort_busy_before", o_busy, 1);
    rst = 1'b1; tick;
    chk("abort_d1", o_d1, 3'b000);
    chk("abort_d2", o_d2, 3'b000);
    chk("abort_d3", o_d3, 0);
    chk("abort_valid", o_valid, 0);
    chk("abort_busy", o_busy, 0);
    chk("abort_done", o_done, 0);
    rst = 1'b0;
    extra = 0;
    for (int i = 0; i < 8; i++) begin
      tick;
      if (o_done || o_valid || o_busy) extra++;
    end
    chk("abort_quiet", extra, 0);
    run_ramp(64, 1'b0);

`ifdef ADC_EMU_OFFSET_EN
    sel = 0; mode = 1'b0;
    offset = 4'sd2; sample = 6'd38; sv = 1'b1; tick;
    sv = 1'b0;
    chk("off2_d1", o_d1, 3'b100);
    tick;
    chk("off2_d2", o_d2, 3'b010);
    tick;
    chk("off2_d3", o_d3, 0);
    offset = 4'sd0; sv = 1'b1; tick;
    sv = 1'b0;
    chk("off0_d1", o_d1, 3'b001);
    tick;
    chk("off0_d2", o_d2, 3'b100);
    tick;
    chk("off0_d3", o_d3, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
